// File: rtl/id_stage_piped_if.sv
// Decode-stage bus: IF/ID instruction + pipeline control + WB write port in,
// hazard-unit source indices and the registered ID/EX entry out.
//   slave  : the decode stage (id_stage_piped)
//   master : whatever drives IF/ID, control and WB (pipeline top or bench)
interface id_stage_piped_if #(
    parameter int unsigned N = 32
);
    // IF/ID and pipeline control
    logic [31:0]  instructionIn;
    logic [N-1:0] pcIn;
    logic         validIn;
    logic         stallIn;
    logic         flushIn;
    logic         HazardIn;
    logic [3:0]   statusIn;
    // register-file write port from WB
    logic         WB_ENIn;
    logic [3:0]   WB_DestIn;
    logic [N-1:0] WB_ValueIn;
    // combinational hazard-unit outputs
    logic [3:0]   src1Out;
    logic [3:0]   src2Out;
    logic         TwoSrcOut;
    // registered ID/EX entry
    logic         validOut;
    logic [N-1:0] pcOut;
    logic [N-1:0] Val_RnOut;
    logic [N-1:0] Val_RmOut;
    logic [3:0]   EXE_CMDOut;
    logic         SOut;
    logic         BOut;
    logic         MEM_R_ENOut;
    logic         MEM_W_ENOut;
    logic         WB_ENOut;
    logic         IOut;
    logic [3:0]   DestOut;
    logic [11:0]  shiftOperandOut;
    logic [23:0]  Imm24Out;

    modport slave (
        input  instructionIn, pcIn, validIn, stallIn, flushIn, HazardIn, statusIn,
               WB_ENIn, WB_DestIn, WB_ValueIn,
        output src1Out, src2Out, TwoSrcOut,
               validOut, pcOut, Val_RnOut, Val_RmOut, EXE_CMDOut, SOut, BOut,
               MEM_R_ENOut, MEM_W_ENOut, WB_ENOut, IOut, DestOut,
               shiftOperandOut, Imm24Out
    );

    modport master (
        output instructionIn, pcIn, validIn, stallIn, flushIn, HazardIn, statusIn,
               WB_ENIn, WB_DestIn, WB_ValueIn,
        input  src1Out, src2Out, TwoSrcOut,
               validOut, pcOut, Val_RnOut, Val_RmOut, EXE_CMDOut, SOut, BOut,
               MEM_R_ENOut, MEM_W_ENOut, WB_ENOut, IOut, DestOut,
               shiftOperandOut, Imm24Out
    );
endinterface

// File: rtl/id_stage_piped.sv
// Decode stage with integrated ID/EX register.
// Decodes one ARM-subset instruction per cycle, reads the register file
// (two async ports, one sync write from WB), checks the condition field
// against {N,Z,C,V} and registers the result for EXE.
// Ports: clk, rst (async active-high), bus (id_stage_piped_if.slave).
// ID/EX update priority: flush (bubble) > stall (hold) > load.
module id_stage_piped #(
    parameter int unsigned N         = 32,
    parameter int unsigned REG_COUNT = 16,
    parameter bit          BYPASS    = 1'b1
) (
    input logic            clk,
    input logic            rst,
    id_stage_piped_if.slave bus
);

    // Register fields are always 4 bits; entries at or above REG_COUNT stay 0.
    localparam int unsigned RF_DEPTH = 16;
    localparam int unsigned CMD_W    = 4;

    typedef struct packed {
        logic             valid;
        logic [N-1:0]     pc;
        logic [N-1:0]     val_rn;
        logic [N-1:0]     val_rm;
        logic [CMD_W-1:0] exe_cmd;
        logic             s;
        logic             b;
        logic             mem_r;
        logic             mem_w;
        logic             wb_en;
        logic             i;
        logic [3:0]       dest;
        logic [11:0]      shift_op;
        logic [23:0]      imm24;
    } idex_t;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] op;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic       is_str;
    logic [3:0] src2;

    assign cond   = bus.instructionIn[31:28];
    assign mode   = bus.instructionIn[27:26];
    assign i_bit  = bus.instructionIn[25];
    assign op     = bus.instructionIn[24:21];
    assign s_bit  = bus.instructionIn[20];
    assign rn     = bus.instructionIn[19:16];
    assign rd     = bus.instructionIn[15:12];
    assign rm     = bus.instructionIn[3:0];
    assign is_str = (mode == 2'b01) && !s_bit;
    // STR reads its store data from Rd through the second port
    assign src2   = is_str ? rd : rm;

    assign bus.src1Out   = rn;
    assign bus.src2Out   = src2;
    assign bus.TwoSrcOut = ~i_bit | is_str;

    // Control decode
    logic [CMD_W-1:0] dec_cmd;
    logic             dec_s;
    logic             dec_b;
    logic             dec_mem_r;
    logic             dec_mem_w;
    logic             dec_wb_en;

    always_comb begin
        dec_cmd   = '0;
        dec_s     = 1'b0;
        dec_b     = 1'b0;
        dec_mem_r = 1'b0;
        dec_mem_w = 1'b0;
        dec_wb_en = 1'b0;
        case (mode)
            2'b00: begin
                dec_s     = s_bit;
                dec_wb_en = 1'b1;
                case (op)
                    4'b1101: dec_cmd = 4'd1;                      // MOV
                    4'b1111: dec_cmd = 4'd9;                      // MVN
                    4'b0100: dec_cmd = 4'd2;                      // ADD
                    4'b0101: dec_cmd = 4'd3;                      // ADC
                    4'b0010: dec_cmd = 4'd4;                      // SUB
                    4'b0110: dec_cmd = 4'd5;                      // SBC
                    4'b0000: dec_cmd = 4'd6;                      // AND
                    4'b1100: dec_cmd = 4'd7;                      // ORR
                    4'b0001: dec_cmd = 4'd8;                      // EOR
                    4'b1010: begin dec_cmd = 4'd4; dec_wb_en = 1'b0; end  // CMP
                    4'b1000: begin dec_cmd = 4'd6; dec_wb_en = 1'b0; end  // TST
                    default: begin
                        dec_s     = 1'b0;
                        dec_wb_en = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec_cmd = 4'd2;
                if (s_bit) begin                                  // LDR
                    dec_mem_r = 1'b1;
                    dec_wb_en = 1'b1;
                end else begin                                    // STR
                    dec_mem_w = 1'b1;
                end
            end
            2'b10:   dec_b = 1'b1;
            default: ;
        endcase
    end

    // Condition check against {N,Z,C,V}
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = bus.statusIn;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Register file
    logic [N-1:0] rf_q [RF_DEPTH];
    logic [N-1:0] rf_d [RF_DEPTH];

    // Out-of-range indices read 0 even when they match the WB destination
    function automatic logic [N-1:0] read_port(
        input logic [3:0]   idx,
        input logic [N-1:0] stored,
        input logic         wb_en,
        input logic [3:0]   wb_dest,
        input logic [N-1:0] wb_val
    );
        if (32'(idx) >= REG_COUNT) return '0;
        if (BYPASS && wb_en && (idx == wb_dest)) return wb_val;
        return stored;
    endfunction

    logic [N-1:0] val_rn;
    logic [N-1:0] val_rm;

    assign val_rn = read_port(rn,   rf_q[rn],   bus.WB_ENIn, bus.WB_DestIn, bus.WB_ValueIn);
    assign val_rm = read_port(src2, rf_q[src2], bus.WB_ENIn, bus.WB_DestIn, bus.WB_ValueIn);

    // WB write commits regardless of stall/flush
    always_comb begin
        rf_d = rf_q;
        if (bus.WB_ENIn && (32'(bus.WB_DestIn) < REG_COUNT)) begin
            rf_d[bus.WB_DestIn] = bus.WB_ValueIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    // ID/EX register next state
    idex_t idex_q;
    idex_t idex_d;
    logic  live;

    assign live = bus.validIn & ~bus.HazardIn;

    always_comb begin
        idex_d = idex_q;
        if (bus.flushIn) begin
            idex_d.valid   = 1'b0;
            idex_d.exe_cmd = '0;
            idex_d.s       = 1'b0;
            idex_d.b       = 1'b0;
            idex_d.mem_r   = 1'b0;
            idex_d.mem_w   = 1'b0;
            idex_d.wb_en   = 1'b0;
        end else if (!bus.stallIn) begin
            idex_d.valid    = live;
            idex_d.pc       = bus.pcIn;
            idex_d.val_rn   = val_rn;
            idex_d.val_rm   = val_rm;
            idex_d.i        = i_bit;
            idex_d.dest     = rd;
            idex_d.shift_op = bus.instructionIn[11:0];
            idex_d.imm24    = bus.instructionIn[23:0];
            // bubbles and failed conditions carry no side effects into EXE
            if (live && cond_pass) begin
                idex_d.exe_cmd = dec_cmd;
                idex_d.s       = dec_s;
                idex_d.b       = dec_b;
                idex_d.mem_r   = dec_mem_r;
                idex_d.mem_w   = dec_mem_w;
                idex_d.wb_en   = dec_wb_en;
            end else begin
                idex_d.exe_cmd = '0;
                idex_d.s       = 1'b0;
                idex_d.b       = 1'b0;
                idex_d.mem_r   = 1'b0;
                idex_d.mem_w   = 1'b0;
                idex_d.wb_en   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.validOut        = idex_q.valid;
    assign bus.pcOut           = idex_q.pc;
    assign bus.Val_RnOut       = idex_q.val_rn;
    assign bus.Val_RmOut       = idex_q.val_rm;
    assign bus.EXE_CMDOut      = idex_q.exe_cmd;
    assign bus.SOut            = idex_q.s;
    assign bus.BOut            = idex_q.b;
    assign bus.MEM_R_ENOut     = idex_q.mem_r;
    assign bus.MEM_W_ENOut     = idex_q.mem_w;
    assign bus.WB_ENOut        = idex_q.wb_en;
    assign bus.IOut            = idex_q.i;
    assign bus.DestOut         = idex_q.dest;
    assign bus.shiftOperandOut = idex_q.shift_op;
    assign bus.Imm24Out        = idex_q.imm24;

endmodule

// File: tb/tb_id_stage_piped.sv
// Bench for id_stage_piped: two instances (BYPASS=1 and BYPASS=0, REG_COUNT=12)
// driven with identical directed stimulus and checked every cycle against a
// behavioural model, plus literal expectations for the key scenarios.
module tb_id_stage_piped;

    localparam int unsigned N  = 32;
    localparam int unsigned RC = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_piped_if #(.N(N)) ifa ();
    id_stage_piped_if #(.N(N)) ifb ();

    id_stage_piped #(.N(N), .REG_COUNT(RC), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    id_stage_piped #(.N(N), .REG_COUNT(RC), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // shared stimulus
    logic [31:0] t_instr = '0;
    logic [31:0] t_pc    = '0;
    logic        t_valid = 1'b0;
    logic        t_stall = 1'b0;
    logic        t_flush = 1'b0;
    logic        t_haz   = 1'b0;
    logic [3:0]  t_stat  = '0;
    logic        t_we    = 1'b0;
    logic [3:0]  t_wd    = '0;
    logic [31:0] t_wv    = '0;

    assign ifa.instructionIn = t_instr;  assign ifb.instructionIn = t_instr;
    assign ifa.pcIn          = t_pc;     assign ifb.pcIn          = t_pc;
    assign ifa.validIn       = t_valid;  assign ifb.validIn       = t_valid;
    assign ifa.stallIn       = t_stall;  assign ifb.stallIn       = t_stall;
    assign ifa.flushIn       = t_flush;  assign ifb.flushIn       = t_flush;
    assign ifa.HazardIn      = t_haz;    assign ifb.HazardIn      = t_haz;
    assign ifa.statusIn      = t_stat;   assign ifb.statusIn      = t_stat;
    assign ifa.WB_ENIn       = t_we;     assign ifb.WB_ENIn       = t_we;
    assign ifa.WB_DestIn     = t_wd;     assign ifb.WB_DestIn     = t_wd;
    assign ifa.WB_ValueIn    = t_wv;     assign ifb.WB_ValueIn    = t_wv;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rn, rm;
        logic [3:0]  cmd;
        logic        s, b, mr, mw, wb, i;
        logic [3:0]  dest;
        logic [11:0] sh;
        logic [23:0] imm;
    } out_t;

    // model state: expected ID/EX entry per instance (0: bypass, 1: no bypass)
    out_t        exp_o  [2];
    out_t        pend_o [2];
    logic [31:0] rf_m    [16];
    logic [31:0] rf_pend [16];
    logic [3:0]  exp_src1, exp_src2;
    logic        exp_two;
    bit          check_en = 1'b0;
    logic [31:0] pc_ctr = 32'h100;

    int checks   = 0;
    int failures = 0;

    // ALU command per op; 0 means the op is not in the supported set
    int cmd_of_op [16] = '{6, 8, 4, 0, 2, 3, 5, 0, 6, 0, 4, 0, 7, 1, 0, 9};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic out_t zero_out();
        out_t z;
        z = '{default: '0};
        return z;
    endfunction

    // ARM style: cond[3:1] picks a base test, cond[0] inverts; 1111 never passes
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
        bit n, z, cf, v, base;
        {n, z, cf, v} = st;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx, input bit byp);
        if (int'(idx) >= RC) return 32'h0;
        if (byp && t_we && idx == t_wd) return t_wv;
        return rf_m[idx];
    endfunction

    function automatic out_t model_next(input out_t cur, input bit byp);
        out_t       n;
        logic [1:0] md;
        logic [3:0] opc;
        n   = cur;
        md  = t_instr[27:26];
        opc = t_instr[24:21];
        if (t_flush) begin
            n.valid = 0; n.cmd = 0; n.s = 0; n.b = 0; n.mr = 0; n.mw = 0; n.wb = 0;
        end else if (!t_stall) begin
            n.pc    = t_pc;
            n.rn    = m_read(t_instr[19:16], byp);
            n.rm    = m_read(exp_src2, byp);
            n.i     = t_instr[25];
            n.dest  = t_instr[15:12];
            n.sh    = t_instr[11:0];
            n.imm   = t_instr[23:0];
            n.valid = t_valid && !t_haz;
            n.cmd = 0; n.s = 0; n.b = 0; n.mr = 0; n.mw = 0; n.wb = 0;
            if (n.valid && cond_ok(t_instr[31:28], t_stat)) begin
                if (md == 2'd0 && cmd_of_op[opc] != 0) begin
                    n.cmd = 4'(cmd_of_op[opc]);
                    n.s   = t_instr[20];
                    n.wb  = !(opc == 4'b1010 || opc == 4'b1000);
                end else if (md == 2'd1) begin
                    n.cmd = 4'd2;
                    if (t_instr[20]) begin n.mr = 1; n.wb = 1; end
                    else             n.mw = 1;
                end else if (md == 2'd2) begin
                    n.b = 1;
                end
            end
        end
        return n;
    endfunction

    // Apply inputs just after a posedge, predict, then advance one clock
    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                        input logic hz, input logic [3:0] stat, input logic we,
                        input logic [3:0] wd, input logic [31:0] wv, input logic r);
        bit is_str;
        t_instr = ins; t_valid = v; t_stall = st; t_flush = fl; t_haz = hz;
        t_stat = stat; t_we = we; t_wd = wd; t_wv = wv;
        t_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
        rst = r;
        is_str   = (ins[27:26] == 2'b01) && !ins[20];
        exp_src1 = ins[19:16];
        exp_src2 = is_str ? ins[15:12] : ins[3:0];
        exp_two  = !ins[25] || is_str;
        if (r) begin
            exp_o[0] = zero_out(); exp_o[1] = zero_out();
            for (int k = 0; k < 16; k++) rf_m[k] = '0;
            pend_o = exp_o;
            rf_pend = rf_m;
            check_en = 1'b1;
        end else begin
            pend_o[0] = model_next(exp_o[0], 1'b1);
            pend_o[1] = model_next(exp_o[1], 1'b0);
            rf_pend = rf_m;
            if (we && int'(wd) < RC) rf_pend[wd] = wv;
        end
        @(posedge clk); #1;
        exp_o = pend_o;
        rf_m  = rf_pend;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [3:0] stat);
        step(ins, 1, 0, 0, 0, stat, 0, 4'd0, 32'd0, 0);
    endtask

    task automatic wb(input logic [3:0] d, input logic [31:0] v);
        step(32'h0, 0, 0, 0, 0, 4'd0, 1, d, v, 0);
    endtask

    task automatic cmp_out(input string tag, input out_t a, input out_t e);
        chk({tag, ".valid"}, 32'(a.valid), 32'(e.valid));
        chk({tag, ".pc"},    a.pc,  e.pc);
        chk({tag, ".rn"},    a.rn,  e.rn);
        chk({tag, ".rm"},    a.rm,  e.rm);
        chk({tag, ".cmd"},   32'(a.cmd), 32'(e.cmd));
        chk({tag, ".ctl"},   32'({a.s, a.b, a.mr, a.mw, a.wb}), 32'({e.s, e.b, e.mr, e.mw, e.wb}));
        chk({tag, ".i"},     32'(a.i),    32'(e.i));
        chk({tag, ".dest"},  32'(a.dest), 32'(e.dest));
        chk({tag, ".sh"},    32'(a.sh),   32'(e.sh));
        chk({tag, ".imm"},   32'(a.imm),  32'(e.imm));
    endtask

    out_t act_a, act_b;
    always_comb begin
        act_a = '{valid: ifa.validOut, pc: ifa.pcOut, rn: ifa.Val_RnOut, rm: ifa.Val_RmOut,
                  cmd: ifa.EXE_CMDOut, s: ifa.SOut, b: ifa.BOut, mr: ifa.MEM_R_ENOut,
                  mw: ifa.MEM_W_ENOut, wb: ifa.WB_ENOut, i: ifa.IOut, dest: ifa.DestOut,
                  sh: ifa.shiftOperandOut, imm: ifa.Imm24Out};
        act_b = '{valid: ifb.validOut, pc: ifb.pcOut, rn: ifb.Val_RnOut, rm: ifb.Val_RmOut,
                  cmd: ifb.EXE_CMDOut, s: ifb.SOut, b: ifb.BOut, mr: ifb.MEM_R_ENOut,
                  mw: ifb.MEM_W_ENOut, wb: ifb.WB_ENOut, i: ifb.IOut, dest: ifb.DestOut,
                  sh: ifb.shiftOperandOut, imm: ifb.Imm24Out};
    end

    // Per-cycle compare against the model, mid-cycle
    always @(negedge clk) begin
        if (check_en) begin
            cmp_out("byp1", act_a, exp_o[0]);
            cmp_out("byp0", act_b, exp_o[1]);
            chk("byp1.src1", 32'(ifa.src1Out),   32'(exp_src1));
            chk("byp1.src2", 32'(ifa.src2Out),   32'(exp_src2));
            chk("byp1.two",  32'(ifa.TwoSrcOut), 32'(exp_two));
            chk("byp0.src2", 32'(ifb.src2Out),   32'(exp_src2));
        end
    end

    localparam logic [31:0] ADD    = 32'hE0821003;  // ADD R1,R2,R3
    localparam logic [31:0] ADDEQ  = 32'h00821003;
    localparam logic [31:0] ADD_R6 = 32'hE0861003;  // ADD R1,R6,R3
    localparam logic [31:0] LDR    = 32'hE5910000;  // LDR R0,[R1]
    localparam logic [31:0] STR    = 32'hE5854000;  // STR R4,[R5]

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // reset with stimulus present
        step(ADD, 1, 0, 0, 0, 4'd0, 1, 4'd2, 32'h77, 1);
        step(ADD, 1, 0, 0, 0, 4'd0, 0, 4'd0, 32'd0, 1);
        chk("lit.reset_valid", 32'(ifa.validOut), 32'd0);
        chk("lit.reset_rn",    ifa.Val_RnOut,     32'd0);
        wb(4'd2, 32'd5); wb(4'd3, 32'd7); wb(4'd4, 32'hAA); wb(4'd5, 32'h100);

        issue(ADD, 4'd0);
        chk("lit.add_cmd",   32'(ifa.EXE_CMDOut), 32'd2);
        chk("lit.add_wb",    32'(ifa.WB_ENOut),   32'd1);
        chk("lit.add_dest",  32'(ifa.DestOut),    32'd1);
        chk("lit.add_rn",    ifa.Val_RnOut,       32'd5);
        chk("lit.add_rm",    ifa.Val_RmOut,       32'd7);
        chk("lit.add_valid", 32'(ifa.validOut),   32'd1);

        // same-cycle WB to R2 while decoding ADD
        step(ADD, 1, 0, 0, 0, 4'd0, 1, 4'd2, 32'h1234, 0);
        chk("lit.bypass1_rn", ifa.Val_RnOut, 32'h1234);
        chk("lit.bypass0_rn", ifb.Val_RnOut, 32'd5);

        issue(ADDEQ, 4'b0000);
        chk("lit.condfail_wb",    32'(ifa.WB_ENOut),   32'd0);
        chk("lit.condfail_cmd",   32'(ifa.EXE_CMDOut), 32'd0);
        chk("lit.condfail_valid", 32'(ifa.validOut),   32'd1);
        issue(ADDEQ, 4'b0100);
        chk("lit.condpass_wb", 32'(ifa.WB_ENOut), 32'd1);

        // stall three cycles; a WB write during the stall still commits
        for (int k = 0; k < 3; k++) step(STR, 1, 1, 0, 0, 4'd0, 1, 4'd6, 32'h66, 0);
        chk("lit.stall_cmd",  32'(ifa.EXE_CMDOut), 32'd2);
        chk("lit.stall_rn",   ifa.Val_RnOut,       32'h1234);
        chk("lit.stall_dest", 32'(ifa.DestOut),    32'd1);
        issue(ADD_R6, 4'd0);
        chk("lit.stall_wb_commit", ifb.Val_RnOut, 32'h66);

        step(ADD, 1, 1, 1, 0, 4'd0, 0, 4'd0, 32'd0, 0);
        chk("lit.flush_valid", 32'(ifa.validOut), 32'd0);
        chk("lit.flush_wb",    32'(ifa.WB_ENOut), 32'd0);

        step(LDR, 1, 0, 0, 1, 4'd0, 0, 4'd0, 32'd0, 0);
        chk("lit.hazard_valid", 32'(ifa.validOut),    32'd0);
        chk("lit.hazard_memr",  32'(ifa.MEM_R_ENOut), 32'd0);
        issue(LDR, 4'd0);
        chk("lit.ldr_memr", 32'(ifa.MEM_R_ENOut), 32'd1);

        issue(STR, 4'd0);
        chk("lit.str_src2", 32'(ifa.src2Out),     32'd4);
        chk("lit.str_two",  32'(ifa.TwoSrcOut),   32'd1);
        chk("lit.str_memw", 32'(ifa.MEM_W_ENOut), 32'd1);
        chk("lit.str_wb",   32'(ifa.WB_ENOut),    32'd0);
        chk("lit.str_rm",   ifa.Val_RmOut,        32'hAA);

        issue(32'hEA000010, 4'd0);
        chk("lit.branch_b", 32'(ifa.BOut), 32'd1);
        issue(32'hEF000000, 4'd0);

        // indices >= REG_COUNT: writes dropped, reads 0 even on bypass match
        wb(4'd13, 32'hDEAD);
        issue(32'hE08D1003, 4'd0);
        chk("lit.oob_rn", ifa.Val_RnOut, 32'd0);
        step(32'hE08E1003, 1, 0, 0, 0, 4'd0, 1, 4'd14, 32'hBEEF, 0);
        chk("lit.oob_bypass_rn", ifa.Val_RnOut, 32'd0);

        // condition sweep over several flag patterns
        for (int c = 0; c < 16; c++) begin
            issue({4'(c), 28'h0821003}, 4'b0000);
            issue({4'(c), 28'h0821003}, 4'b0110);
            issue({4'(c), 28'h0821003}, 4'b1001);
            issue({4'(c), 28'h0821003}, 4'b1100);
        end
        // opcode sweep, S=1, I alternating
        for (int o = 0; o < 16; o++) begin
            logic [3:0] op4;
            op4 = 4'(o);
            issue({4'hE, 2'b00, op4[0], op4, 1'b1, 4'd2, 4'd1, 12'h003}, 4'd0);
        end

        // reset while stalled: outputs clear immediately and stay clear
        step(ADD, 1, 1, 0, 0, 4'd0, 0, 4'd0, 32'd0, 1);
        step(ADD, 1, 1, 0, 0, 4'd0, 0, 4'd0, 32'd0, 1);
        chk("lit.rst_stall_valid", 32'(ifa.validOut),   32'd0);
        chk("lit.rst_stall_cmd",   32'(ifa.EXE_CMDOut), 32'd0);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] r4;
            r4 = 4'(k);
            issue({12'hE08, r4, 4'h1, 8'h00, r4}, 4'd0);
            chk("lit.rf_cleared", ifa.Val_RnOut, 32'd0);
        end
        step(32'h0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 32'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
